// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg
//   Shared types and constants for the DDRAM port arbiter.
//   - arb_state_t : arbiter FSM states
//   - client_t    : requester identifiers
//   - address shift / pad constants used to build 28-bit byte addresses
//   - lane16()    : picks one 16-bit lane out of a 64-bit DDRAM word
package ddram_arb_pkg;

  localparam int MEM_AW    = 28;  // downstream byte address width
  localparam int LD_AW     = 25;  // loader byte address width
  localparam int ROM_AW    = 20;  // ROM 64-bit word address width
  localparam int LD_PAD    = MEM_AW - LD_AW;      // zero bits above loader address
  localparam int ROM_SHIFT = 3;                   // 64-bit word -> byte address
  localparam int ROM_PAD   = MEM_AW - ROM_AW - ROM_SHIFT;
  localparam int SAV_SHIFT = 1;                   // 16-bit word -> byte address

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    CL_LD,
    CL_ROM,
    CL_SAV
  } client_t;

  // DDRAM words are big-endian in lane order: k=0 is the top 16 bits.
  function automatic logic [15:0] lane16(input logic [63:0] d, input logic [1:0] k);
    logic [15:0] r;
    case (k)
      2'd0:    r = d[63:48];
      2'd1:    r = d[47:32];
      2'd2:    r = d[31:16];
      default: r = d[15:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arb_toggle_port.sv
// arb_toggle_port
//   Client side of one toggle handshake: flags a pending request while
//   req != ack, flips ack when the arbiter finishes the transaction and
//   optionally captures read data on that same edge so data and ack
//   become visible together.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_req         client request toggle
//   i_done        pulse: transaction for this client complete
//   i_load        capture i_data along with i_done (reads only)
//   i_data        read data to capture
//   o_ack         client acknowledge toggle
//   o_pend        request outstanding
//   o_dout        last captured read data, held until the next read
import ddram_arb_pkg::*;

module arb_toggle_port #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_done,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  output logic          o_ack,
  output logic          o_pend,
  output logic [DW-1:0] o_dout
);

  logic          r_ack;
  logic [DW-1:0] r_dout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack  <= 1'b0;
      r_dout <= '0;
    end else if (i_done) begin
      r_ack <= ~r_ack;
      if (i_load) r_dout <= i_data;
    end
  end

  assign o_ack  = r_ack;
  assign o_pend = i_req ^ r_ack;
  assign o_dout = r_dout;

endmodule

// File: rtl/ddram_arbiter.sv
// ddram_arbiter
//   Shares the single toggle-handshake DDRAM port among the ROM loader
//   (writes), ROM reads and cartridge save-RAM (reads/writes). One
//   downstream transaction at a time; priority LD > ROM > SAV, except that
//   SAV overtakes ROM once ROM has been granted STARVE_MAX times in a row
//   while SAV was waiting.
// Ports:
//   clk_sys, reset                      clock, async active-high reset
//   ld_addr/ld_din/ld_req/ld_ack        loader write stream
//   rom_addr/rom_req/rom_ack/rom_dout   ROM 64-bit reads
//   sav_addr/sav_din/sav_we/sav_req/
//   sav_ack/sav_dout                    save-RAM 16-bit reads/writes
//   mem_addr/mem_din                    downstream byte address / write data
//   mem_we_req/mem_we_ack               downstream write toggle pair
//   mem_rd_req/mem_rd_ack/mem_dout      downstream read toggle pair + data
import ddram_arb_pkg::*;

module ddram_arbiter #(
  parameter logic [27:0] SAV_BASE   = 28'h2000000,
  parameter int          SAV_AW     = 16,
  parameter int          STARVE_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [24:0]       ld_addr,
  input  logic [15:0]       ld_din,
  input  logic              ld_req,
  output logic              ld_ack,
  input  logic [19:0]       rom_addr,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [63:0]       rom_dout,
  input  logic [SAV_AW-1:0] sav_addr,
  input  logic [15:0]       sav_din,
  input  logic              sav_we,
  input  logic              sav_req,
  output logic              sav_ack,
  output logic [15:0]       sav_dout,
  output logic [27:0]       mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we_req,
  input  logic              mem_we_ack,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [63:0]       mem_dout
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t  r_state;
  client_t     r_client;
  logic        r_wr;          // latched direction: 1 = downstream write
  logic [27:0] r_mem_addr;
  logic [15:0] r_mem_din;
  logic        r_we_req;
  logic        r_rd_req;
  logic [CW-1:0] r_starve;

  logic        w_ld_pend, w_rom_pend, w_sav_pend;
  logic        w_grant;
  client_t     w_gnt;
  logic [27:0] w_ld_byte, w_rom_byte, w_sav_byte;
  logic        w_match;
  logic        w_done;
  logic        w_rd_done;
  logic [15:0] w_sav_lane;
  logic        w_ld_dout_unused;
  logic        w_unused;

  // ---------------------------------------------------------------- clients
  arb_toggle_port #(.DW(1)) u_ld (
    .i_clk  (clk_sys),
    .i_rst  (reset),
    .i_req  (ld_req),
    .i_done (w_done && (r_client == CL_LD)),
    .i_load (1'b0),
    .i_data (1'b0),
    .o_ack  (ld_ack),
    .o_pend (w_ld_pend),
    .o_dout (w_ld_dout_unused)
  );

  arb_toggle_port #(.DW(64)) u_rom (
    .i_clk  (clk_sys),
    .i_rst  (reset),
    .i_req  (rom_req),
    .i_done (w_done && (r_client == CL_ROM)),
    .i_load (w_rd_done),
    .i_data (mem_dout),
    .o_ack  (rom_ack),
    .o_pend (w_rom_pend),
    .o_dout (rom_dout)
  );

  arb_toggle_port #(.DW(16)) u_sav (
    .i_clk  (clk_sys),
    .i_rst  (reset),
    .i_req  (sav_req),
    .i_done (w_done && (r_client == CL_SAV)),
    .i_load (w_rd_done),
    .i_data (w_sav_lane),
    .o_ack  (sav_ack),
    .o_pend (w_sav_pend),
    .o_dout (sav_dout)
  );

  // ld_addr[0] is meaningless for 16-bit writes; the loader has no read data.
  assign w_unused = ^{ld_addr[0], w_ld_dout_unused};

  // ------------------------------------------------------- address mapping
  assign w_ld_byte  = {{LD_PAD{1'b0}}, ld_addr[24:1], 1'b0};
  assign w_rom_byte = {{ROM_PAD{1'b0}}, rom_addr, {ROM_SHIFT{1'b0}}};
  assign w_sav_byte = SAV_BASE + 28'({sav_addr, {SAV_SHIFT{1'b0}}});

  // Lane chosen from the latched byte address, so it matches the issued read.
  assign w_sav_lane = lane16(mem_dout, r_mem_addr[2:1]);

  // ------------------------------------------------------- grant selection
  always_comb begin
    w_grant = w_ld_pend | w_rom_pend | w_sav_pend;
    w_gnt   = CL_LD;
    if (w_ld_pend)
      w_gnt = CL_LD;
    else if (w_sav_pend && (r_starve == CW'(STARVE_MAX)))
      w_gnt = CL_SAV;
    else if (w_rom_pend)
      w_gnt = CL_ROM;
    else
      w_gnt = CL_SAV;
  end

  assign w_match   = r_wr ? (mem_we_ack == r_we_req) : (mem_rd_ack == r_rd_req);
  assign w_done    = (r_state == WAIT) && w_match;
  assign w_rd_done = w_done && !r_wr;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_client   <= CL_LD;
      r_wr       <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_we_req   <= 1'b0;
      r_rd_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_client <= w_gnt;
            case (w_gnt)
              CL_LD: begin
                r_mem_addr <= w_ld_byte;
                r_mem_din  <= ld_din;
                r_wr       <= 1'b1;
              end
              CL_ROM: begin
                r_mem_addr <= w_rom_byte;
                r_wr       <= 1'b0;
              end
              default: begin
                r_mem_addr <= w_sav_byte;
                r_mem_din  <= sav_din;
                r_wr       <= sav_we;
              end
            endcase
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_wr) r_we_req <= ~r_we_req;
          else      r_rd_req <= ~r_rd_req;
          r_state <= WAIT;
        end
        WAIT: begin
          // Client ack/data are updated by the port instances on this edge.
          if (w_match) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ starvation guard
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!w_sav_pend) begin
      r_starve <= '0;
    end else if ((r_state == IDLE) && w_grant) begin
      if (w_gnt == CL_SAV)
        r_starve <= '0;
      else if ((w_gnt == CL_ROM) && (r_starve != CW'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_we_req = r_we_req;
  assign mem_rd_req = r_rd_req;

endmodule

// File: tb/tb_ddram_arbiter.sv
module tb_ddram_arbiter;

  localparam int LAT = 3;  // downstream ack delay in cycles after its req

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [24:0] ld_addr = '0;
  logic [15:0] ld_din  = '0;
  logic        ld_req  = 1'b0;
  logic        ld_ack;
  logic [19:0] rom_addr = '0;
  logic        rom_req  = 1'b0;
  logic        rom_ack;
  logic [63:0] rom_dout;
  logic [15:0] sav_addr = '0;
  logic [15:0] sav_din  = '0;
  logic        sav_we   = 1'b0;
  logic        sav_req  = 1'b0;
  logic        sav_ack;
  logic [15:0] sav_dout;
  logic [27:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we_req;
  logic        mem_we_ack;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [63:0] mem_dout;
  logic [63:0] dram_data = '0;

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  always #5 clk_sys = ~clk_sys;

  assign mem_dout = dram_data;

  ddram_arbiter dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ld_addr    (ld_addr),
    .ld_din     (ld_din),
    .ld_req     (ld_req),
    .ld_ack     (ld_ack),
    .rom_addr   (rom_addr),
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .rom_dout   (rom_dout),
    .sav_addr   (sav_addr),
    .sav_din    (sav_din),
    .sav_we     (sav_we),
    .sav_req    (sav_req),
    .sav_ack    (sav_ack),
    .sav_dout   (sav_dout),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we_req (mem_we_req),
    .mem_we_ack (mem_we_ack),
    .mem_rd_req (mem_rd_req),
    .mem_rd_ack (mem_rd_ack),
    .mem_dout   (mem_dout)
  );

  // Downstream model: ack follows req LAT cycles after the req toggle.
  int rd_cnt, we_cnt;
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_rd_ack <= 1'b0;
      mem_we_ack <= 1'b0;
      rd_cnt     <= 0;
      we_cnt     <= 0;
    end else begin
      if (mem_rd_req != mem_rd_ack) begin
        if (rd_cnt == LAT - 1) begin
          mem_rd_ack <= mem_rd_req;
          rd_cnt     <= 0;
        end else rd_cnt <= rd_cnt + 1;
      end
      if (mem_we_req != mem_we_ack) begin
        if (we_cnt == LAT - 1) begin
          mem_we_ack <= mem_we_req;
          we_cnt     <= 0;
        end else we_cnt <= we_cnt + 1;
      end
    end
  end

  // Log of downstream toggles {is_write, byte address}, plus overlap watch.
  logic [28:0] glog[$];
  logic prev_we = 1'b0, prev_rd = 1'b0;
  always @(negedge clk_sys) begin
    prev_we <= mem_we_req;
    prev_rd <= mem_rd_req;
    if (!reset) begin
      if (prev_we != mem_we_req) glog.push_back({1'b1, mem_addr});
      if (prev_rd != mem_rd_req) glog.push_back({1'b0, mem_addr});
      if ((mem_rd_req != mem_rd_ack) && (mem_we_req != mem_we_ack))
        overlap <= overlap + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (((ld_req != ld_ack) || (rom_req != rom_ack) || (sav_req != sav_ack)) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 64'(n < 200), 64'd1);
  endtask

  task automatic wait_rom(input string tag);
    int n = 0;
    while ((rom_req != rom_ack) && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  initial begin
    // ---- reset state
    steps(2);
    check("rst_toggles", {ld_ack, rom_ack, sav_ack, mem_we_req, mem_rd_req}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rom_dout", rom_dout, 0);
    check("rst_sav_dout", sav_dout, 0);
    reset = 1'b0;
    steps(1);

    // ---- loader write: grant at next edge, req one edge later, ack +3, client ack +1
    ld_addr = 25'h000102; ld_din = 16'hA55A; ld_req = ~ld_req;
    steps(1);
    check("ld_mem_addr", mem_addr, 28'h0000102);
    check("ld_mem_din", mem_din, 16'hA55A);
    check("ld_we_req_pre", mem_we_req, 0);
    steps(1);
    check("ld_we_req", mem_we_req, 1);
    steps(3);
    check("ld_we_ack", mem_we_ack, 1);
    check("ld_ack_pre", ld_ack, 0);
    steps(1);
    check("ld_ack", ld_ack, 1);
    check("ld_no_read", mem_rd_req, 0);

    // ---- ROM read
    dram_data = 64'h0123456789ABCDEF;
    rom_addr = 20'h00010; rom_req = ~rom_req;
    steps(1);
    check("rom_mem_addr", mem_addr, 28'h0000080);
    steps(4);
    check("rom_ack_pre", rom_ack, 0);
    steps(1);
    check("rom_ack", rom_ack, 1);
    check("rom_dout", rom_dout, 64'h0123456789ABCDEF);
    check("rom_rd_req", mem_rd_req, 1);

    // ---- SAV read, lane 3
    sav_addr = 16'h0003; sav_we = 1'b0; sav_req = ~sav_req;
    steps(1);
    check("sav_mem_addr", mem_addr, 28'h2000006);
    steps(5);
    check("sav_ack", sav_ack, 1);
    check("sav_dout", sav_dout, 16'hCDEF);
    check("sav_rom_hold", rom_dout, 64'h0123456789ABCDEF);

    // ---- priority: all three pending together
    glog.delete();
    dram_data = 64'hFEDCBA9876543210;
    ld_addr  = 25'h0000200; ld_din = 16'h1111;
    rom_addr = 20'h00020;
    sav_addr = 16'h0010; sav_din = 16'h2222; sav_we = 1'b1;
    ld_req = ~ld_req; rom_req = ~rom_req; sav_req = ~sav_req;
    wait_idle("prio_timeout");
    check("prio_count", glog.size(), 3);
    check("prio_0_ld", glog[0], {1'b1, 28'h0000200});
    check("prio_1_rom", glog[1], {1'b0, 28'h0000100});
    check("prio_2_sav", glog[2], {1'b1, 28'h2000020});
    check("prio_rom_dout", rom_dout, 64'hFEDCBA9876543210);
    check("prio_sav_hold", sav_dout, 16'hCDEF);
    check("prio_mem_din", mem_din, 16'h2222);

    // ---- starvation: ROM re-requests back to back, SAV write waiting
    glog.delete();
    sav_addr = 16'h0020; sav_din = 16'h3333; sav_we = 1'b1;
    rom_addr = 20'h00030;
    sav_req = ~sav_req; rom_req = ~rom_req;
    for (int i = 0; i < 6; i++) begin
      wait_rom("starve_rom_timeout");
      if (i < 5) rom_req = ~rom_req;
    end
    wait_idle("starve_timeout");
    check("starve_count", glog.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) check("starve_sav", glog[i], {1'b1, 28'h2000040});
      else        check("starve_rom", glog[i], {1'b0, 28'h0000180});
    end

    // ---- async reset while a ROM read is in WAIT
    dram_data = 64'h1122334455667788;
    rom_addr = 20'h00005; rom_req = ~rom_req;
    steps(3);
    check("rst_inflight", mem_rd_req ^ mem_rd_ack, 1);
    #2;
    reset = 1'b1;
    ld_req = 1'b0; rom_req = 1'b0; sav_req = 1'b0;
    #1;
    check("arst_toggles", {ld_ack, rom_ack, sav_ack, mem_we_req, mem_rd_req}, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_rom_dout", rom_dout, 0);
    check("arst_sav_dout", sav_dout, 0);
    steps(1);
    reset = 1'b0;
    steps(1);
    rom_addr = 20'h00005; rom_req = 1'b1;
    steps(1);
    check("post_rst_addr", mem_addr, 28'h0000028);
    steps(5);
    check("post_rst_ack", rom_ack, 1);
    check("post_rst_dout", rom_dout, 64'h1122334455667788);

    check("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddram_arbiter.md
Name: ddram_arbiter

Overview:
- Shares the single toggle-handshake DDRAM port (ddram) among three requesters: the ROM loader write stream, Virtual_Toplevel ROM reads, and a new cartridge save-RAM port.
- Sits in emu between the requesters and ddram, replacing the direct rom_wr / rom_rd wiring.
- Only one downstream transaction is in flight at a time.
- Fixed priority with a starvation guard for save-RAM.

Parameters:
- SAV_BASE, 28'h2000000: byte base address of the save-RAM region in DDRAM.
- SAV_AW, 16: save-RAM word-address width, in 16-bit words.
- STARVE_MAX, 4: consecutive ROM grants allowed while save-RAM is pending.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ld_addr  in  25  loader byte address; bit 0 ignored.
- ld_din  in  16  loader write data, already byte-swapped.
- ld_req  in  1  loader request toggle.
- ld_ack  out  1  loader acknowledge toggle.
- rom_addr  in  20  ROM 64-bit word address.
- rom_req  in  1  ROM read request toggle.
- rom_ack  out  1  ROM acknowledge toggle.
- rom_dout  out  64  ROM read data.
- sav_addr  in  SAV_AW  save-RAM word address.
- sav_din  in  16  save-RAM write data.
- sav_we  in  1  1 = write, 0 = read; sampled at grant.
- sav_req  in  1  save-RAM request toggle.
- sav_ack  out  1  save-RAM acknowledge toggle.
- sav_dout  out  16  save-RAM read data.
- mem_addr  out  28  downstream byte address.
- mem_din  out  16  downstream write data.
- mem_we_req  out  1  downstream write request toggle.
- mem_we_ack  in  1  downstream write acknowledge toggle.
- mem_rd_req  out  1  downstream read request toggle.
- mem_rd_ack  in  1  downstream read acknowledge toggle.
- mem_dout  in  64  downstream read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, starve counter 0.
- Pending condition: a client is pending when its req != ack. Requests are sampled only in IDLE.
- Priority: LD > ROM > SAV. Exception: if the starve counter == STARVE_MAX and SAV is pending, SAV wins over ROM. LD always wins.
- Starve counter:
  - Increments on each ROM grant made while SAV is pending, saturating at STARVE_MAX.
  - Clears on a SAV grant, and whenever SAV is not pending.
- States:
  - IDLE: if any client is pending, latch client id, address, data and direction, then go to ISSUE.
  - ISSUE (1 cycle): toggle mem_we_req (LD, or SAV with we=1) or mem_rd_req (ROM, or SAV with we=0); go to WAIT.
  - WAIT: stay until the matching ack equals its req. Then capture data (reads), toggle the client's ack, and return to IDLE.
- Address mapping:
  - LD: {3'b0, ld_addr[24:1], 1'b0}.
  - ROM: {5'b0, rom_addr, 3'b000}.
  - SAV: SAV_BASE + {sav_addr, 1'b0}, an unsigned 28-bit add with wrap ignored.
- SAV read lane select by byte-address bits [2:1] = k: sav_dout = mem_dout[63-16k -: 16], so k=0 selects [63:48].
- Client-ack timing: rom_dout/sav_dout are valid in the same cycle the client ack toggles, and hold until the next read for that client.
- Latency: client ack toggles 2 cycles after grant plus the downstream latency.
  - Grant cycle G, downstream req toggles at G+1.
  - Downstream ack observed at cycle A; client ack toggles at A+1.
- New requests:
  - A client toggling req again before its ack is a protocol error; the arbiter does not check for it.
  - A request arriving while busy waits until the next IDLE.
- Simultaneous events: a client may re-request in the cycle its ack toggles; the next IDLE sees it as pending.
- Reset mid-transaction: async abort to IDLE with all toggles cleared. ddram and the clients are reset by the same signal, so toggle pairs stay matched.
- ROM reads during an active load are starved by design; the loader paces itself on ld_ack.

Decomposition:
- Package ddram_arb_pkg holds:
  - typedef enum {IDLE, ISSUE, WAIT} arb_state_t;
  - typedef enum {CL_LD, CL_ROM, CL_SAV} client_t;
  - address-shift constants.
- Sub-module arb_toggle_port #(DW): pending detect, ack toggle and data capture register; instantiated per client.
- Grant selection stays combinational inside ddram_arbiter.

Test Plan:
- Loader write only: ld_addr=25'h000102, ld_din=16'hA55A, ld_req toggled, downstream acks 3 cycles after its req.
  - Expect mem_addr=28'h0000102, mem_din=16'hA55A, mem_we_req toggles once.
  - Expect ld_ack toggles 1 cycle after mem_we_ack matches.
- ROM read: rom_addr=20'h00010, mem_dout=64'h0123456789ABCDEF.
  - Expect mem_addr=28'h0000080 and rom_dout=64'h0123456789ABCDEF when rom_ack toggles.
- SAV read lane: sav_addr=16'h0003, sav_we=0, SAV_BASE default.
  - Expect mem_addr=28'h2000006 and sav_dout=16'hCDEF from the same mem_dout.
- Priority: LD, ROM and SAV all pending in the same cycle.
  - Expect grant order LD, ROM, SAV, with exactly one downstream toggle outstanding at any time.
- Starvation: ROM re-requests continuously while a SAV write is pending.
  - Expect exactly 4 ROM grants, then the SAV grant, then ROM resumes.
- Async reset asserted in WAIT: mid-cycle reset clears all acks, mem_*_req and state within the same cycle.
  - After release, a fresh ROM request completes normally.
